// File: rtl/approx_eval_pkg.sv
// ---------------------------------------------------------------------------
// approx_eval_pkg
// Shared types and helpers for the approximate-arithmetic evaluation
// sequencers (adder sweep today, multiplier sweep later).
//   sweep_state_e : IDLE / SWEEP / DONE state encoding of a sweep controller
//   mag_t         : wide unsigned magnitude container used by abs_diff
//   abs_diff()    : |exact - approx| of two unsigned values.  Callers
//                   zero-extend into mag_t and slice the result back to
//                   their own sum width, so one function serves every W.
// ---------------------------------------------------------------------------
package approx_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_e;

   localparam int MAG_W = 32;
   typedef logic [MAG_W-1:0] mag_t;

   // Comparing before subtracting gives the same magnitude as a signed
   // (width+1)-bit difference followed by an absolute value, with no overflow.
   function automatic mag_t abs_diff(input mag_t exact, input mag_t approx);
      return (exact >= approx) ? (exact - approx) : (approx - exact);
   endfunction

endpackage

// File: rtl/approx_err_calc.sv
// ---------------------------------------------------------------------------
// approx_err_calc
// Combinational error evaluator for one adder sweep vector.
// Parameters: W  - addend width (sum width W+1)
// Ports:
//   vec     in  2W   sweep vector, a = vec[W-1:0], b = vec[2W-1:W]
//   dut_sum in  W+1  approximate sum returned by the adder under test
//   exact   out W+1  exact a + b (zero-extended)
//   err     out W+1  |exact - dut_sum|
// ---------------------------------------------------------------------------
module approx_err_calc
   import approx_eval_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [2*W-1:0] vec,
   input  logic [W:0]     dut_sum,
   output logic [W:0]     exact,
   output logic [W:0]     err
);

   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   mag_t         diff_full;
   logic         unused_diff_hi;

   assign op_a  = vec[W-1:0];
   assign op_b  = vec[2*W-1:W];
   assign exact = {1'b0, op_a} + {1'b0, op_b};

   assign diff_full = abs_diff(mag_t'(exact), mag_t'(dut_sum));
   // Both inputs fit in W+1 bits, so the magnitude does too.
   assign err            = diff_full[W:0];
   assign unused_diff_hi = |diff_full[MAG_W-1:W+1];

endmodule

// File: rtl/approx_adder_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// approx_adder_sweep_ctrl
// Drives every operand pair through an external combinational approximate
// W-bit adder and accumulates error statistics against a runtime threshold.
// Optional build macro: SWEEP_EARLY_ABORT_EN - the first vector whose error
// exceeds the threshold ends the sweep (after its statistics are folded in).
// Parameters: W (addend width), VW = 2*W (sweep vector width, derived)
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a sweep (accepted in IDLE only)
//   et              error threshold, latched when start is accepted
//   dut_a, dut_b    operands to the adder (low / high half of vec)
//   dut_sum         approximate sum from the adder
//   busy            high in SWEEP
//   done            one-cycle pulse, results final
//   pass            max_err <= latched et, valid from done to next start
//   max_err         largest absolute error seen
//   err_cnt         number of vectors with nonzero error
//   first_fail_vec  first vec whose error exceeded et (0 if none)
//   fail_seen       some vector exceeded et
// Handshake: start is a level sampled on the rising edge only while IDLE;
// done is a single-cycle strobe, and results stay stable until the next
// accepted start.
// ---------------------------------------------------------------------------
module approx_adder_sweep_ctrl
   import approx_eval_pkg::*;
#(
   parameter int W  = 2,
   parameter int VW = 2 * W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [W:0]    et,
   output logic [W-1:0]  dut_a,
   output logic [W-1:0]  dut_b,
   input  logic [W:0]    dut_sum,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [W:0]    max_err,
   output logic [VW:0]   err_cnt,
   output logic [VW-1:0] first_fail_vec,
   output logic          fail_seen
);

   localparam logic [VW-1:0] VEC_ONE = VW'(1);
   localparam logic [VW:0]   CNT_ONE = (VW + 1)'(1);

   sweep_state_e  state_q, state_d;
   logic [VW-1:0] vec_q, vec_d;
   logic [W:0]    et_q, et_d;
   logic [W:0]    max_err_q, max_err_d;
   logic [VW:0]   err_cnt_q, err_cnt_d;
   logic [VW-1:0] ffv_q, ffv_d;
   logic          fail_seen_q, fail_seen_d;
   logic          pass_q, pass_d;

   logic [W:0]    err;
   logic [W:0]    exact_unused;
   logic          over_et;
   logic          go_done;

   approx_err_calc #(.W(W)) u_err_calc (
      .vec     (vec_q),
      .dut_sum (dut_sum),
      .exact   (exact_unused),
      .err     (err)
   );

   assign over_et = (err > et_q);

   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      et_d        = et_q;
      max_err_d   = max_err_q;
      err_cnt_d   = err_cnt_q;
      ffv_d       = ffv_q;
      fail_seen_d = fail_seen_q;
      pass_d      = pass_q;
      go_done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SWEEP;
               vec_d       = '0;
               et_d        = et;
               max_err_d   = '0;
               err_cnt_d   = '0;
               ffv_d       = '0;
               fail_seen_d = 1'b0;
               pass_d      = 1'b0;
            end
         end
         SWEEP: begin
            if (err > max_err_q) max_err_d = err;
            if (err != '0)       err_cnt_d = err_cnt_q + CNT_ONE;
            if (over_et && !fail_seen_q) begin
               ffv_d       = vec_q;
               fail_seen_d = 1'b1;
            end
            go_done = (vec_q == '1);
`ifdef SWEEP_EARLY_ABORT_EN
            if (over_et) go_done = 1'b1;
`endif
            if (go_done) begin
               state_d = DONE;
               // Uses max_err_d so the final vector is already included.
               pass_d  = (max_err_d <= et_q);
            end else begin
               vec_d = vec_q + VEC_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            vec_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         et_q        <= '0;
         max_err_q   <= '0;
         err_cnt_q   <= '0;
         ffv_q       <= '0;
         fail_seen_q <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         et_q        <= et_d;
         max_err_q   <= max_err_d;
         err_cnt_q   <= err_cnt_d;
         ffv_q       <= ffv_d;
         fail_seen_q <= fail_seen_d;
         pass_q      <= pass_d;
      end
   end

   assign dut_a          = vec_q[W-1:0];
   assign dut_b          = vec_q[VW-1:W];
   assign busy           = (state_q == SWEEP);
   assign done           = (state_q == DONE);
   assign pass           = pass_q;
   assign max_err        = max_err_q;
   assign err_cnt        = err_cnt_q;
   assign first_fail_vec = ffv_q;
   assign fail_seen      = fail_seen_q;

endmodule

// File: tb/tb_approx_adder_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_approx_adder_sweep_ctrl
// Bench for approx_adder_sweep_ctrl at W=2.  A behavioural adder model
// answers dut_a/dut_b in one of three modes (exact, stuck at zero, exact with
// LSB forced high).  Each sweep pushes its hand-computed result record into
// exp_q; a monitor pops and compares on every done pulse.
// Honours SWEEP_EARLY_ABORT_EN for the stuck-at-zero expectations.
// ---------------------------------------------------------------------------
module tb_approx_adder_sweep_ctrl;

   localparam int W  = 2;
   localparam int VW = 2 * W;

   localparam logic [1:0] M_EXACT = 2'd0;
   localparam logic [1:0] M_ZERO  = 2'd1;
   localparam logic [1:0] M_LSB1  = 2'd2;

   typedef struct packed {
      logic        pass;
      logic [2:0]  max_err;
      logic [4:0]  err_cnt;
      logic [3:0]  ffv;
      logic        fail_seen;
      logic [7:0]  busy_cyc;
      logic [7:0]  lat;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W:0]    et;
   logic [W-1:0]  dut_a, dut_b;
   logic [W:0]    dut_sum;
   logic          busy, done, pass, fail_seen;
   logic [W:0]    max_err;
   logic [VW:0]   err_cnt;
   logic [VW-1:0] first_fail_vec;
   logic [1:0]    mode;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   approx_adder_sweep_ctrl #(.W(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .et             (et),
      .dut_a          (dut_a),
      .dut_b          (dut_b),
      .dut_sum        (dut_sum),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .max_err        (max_err),
      .err_cnt        (err_cnt),
      .first_fail_vec (first_fail_vec),
      .fail_seen      (fail_seen)
   );

   // Approximate adder stand-in.
   always_comb begin
      dut_sum = '0;
      case (mode)
         M_EXACT: dut_sum = {1'b0, dut_a} + {1'b0, dut_b};
         M_ZERO:  dut_sum = '0;
         M_LSB1:  dut_sum = ({1'b0, dut_a} + {1'b0, dut_b}) | 3'b001;
         default: dut_sum = '0;
      endcase
   end

   // ---------------- scoreboard ----------------
   exp_t exp_q[$];
   int   vectors = 0;
   int   fails   = 0;
   int   start_cyc = 0;
   int   busy_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("pass",           pass,            e.pass);
               check("max_err",        max_err,         e.max_err);
               check("err_cnt",        err_cnt,         e.err_cnt);
               check("first_fail_vec", first_fail_vec,  e.ffv);
               check("fail_seen",      fail_seen,       e.fail_seen);
               check("busy_cycles",    busy_cnt,        e.busy_cyc);
               check("done_latency",   cyc - start_cyc, e.lat);
            end
            busy_cnt = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_drained(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", exp_q.size(), 0);
      if (exp_q.size() != 0) exp_q.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run_sweep(input logic [1:0] m, input logic [2:0] et_v,
                            input exp_t e, input bit poke_on_done);
      int n;
      mode = m;
      et   = et_v;
      exp_q.push_back(e);
      pulse_start();
      if (poke_on_done) begin
         n = 0;
         while (!done && n < 100) begin
            @(negedge clk);
            n++;
         end
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("start_on_done_ignored", busy, 1'b0);
      end
      wait_drained(100);
   endtask

   // Expected records: {pass, max_err, err_cnt, ffv, fail_seen, busy, latency}
   exp_t e_exact, e_zero, e_lsb1;

   initial begin
      e_exact = '{1'b1, 3'd0, 5'd0,  4'h0, 1'b0, 8'd16, 8'd17};
      e_lsb1  = '{1'b1, 3'd1, 5'd8,  4'h0, 1'b0, 8'd16, 8'd17};
`ifdef SWEEP_EARLY_ABORT_EN
      e_zero  = '{1'b0, 3'd3, 5'd3,  4'h3, 1'b1, 8'd4,  8'd5};
`else
      e_zero  = '{1'b0, 3'd6, 5'd15, 4'h3, 1'b1, 8'd16, 8'd17};
`endif
      rst_n = 1'b0;
      start = 1'b0;
      et    = 3'd2;
      mode  = M_EXACT;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {dut_a, dut_b, busy, done, pass, max_err, err_cnt, first_fail_vec, fail_seen}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Exact adder: clean pass.
      run_sweep(M_EXACT, 3'd2, e_exact, 1'b0);

      // Stuck-at-zero adder; results must hold in IDLE afterwards.
      run_sweep(M_ZERO, 3'd2, e_zero, 1'b0);
      repeat (3) @(negedge clk);
      check("hold_max_err",   max_err,        e_zero.max_err);
      check("hold_err_cnt",   err_cnt,        e_zero.err_cnt);
      check("hold_ffv",       first_fail_vec, e_zero.ffv);
      check("hold_pass",      pass,           e_zero.pass);
      check("hold_idle_busy", busy,           1'b0);

      // LSB forced high, plus a start pulse during the done cycle.
      run_sweep(M_LSB1, 3'd2, e_lsb1, 1'b1);

      // Second start and et change mid-sweep must be ignored.
      mode = M_ZERO;
      et   = 3'd2;
      exp_q.push_back(e_zero);
      pulse_start();
      repeat (3) @(negedge clk);
      start = 1'b1;
      et    = 3'd0;
      @(negedge clk);
      start = 1'b0;
      wait_drained(100);
      et = 3'd2;

      // Reset in sweep cycle 8: everything returns to zero, no done.
      mode = M_ZERO;
      pulse_start();
      repeat (7) @(negedge clk);
      check("busy_before_reset", busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs",
            {dut_a, dut_b, busy, done, pass, max_err, err_cnt, first_fail_vec, fail_seen}, '0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("no_done_after_reset", done, 1'b0);

      // Clean full sweep after the aborted one.
      run_sweep(M_ZERO, 3'd2, e_zero, 1'b0);
      run_sweep(M_EXACT, 3'd2, e_exact, 1'b0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d expected 0 outstanding", exp_q.size());
      $fatal(1, "watchdog expired");
   end

endmodule
